// File: rtl/pixel_stream_packer.sv
// Packs 24-bit RGB pixels into 32-bit AXI4-Stream words per line (zero-padded tail), tuser=SOF, tlast=EOL.
// Latency: word visible 2 cycles after the completing pixel; in_ready drops while >=4 bytes queued or a line flush is pending.
module pixel_stream_packer #(
  parameter int DIM_W = 13
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic [DIM_W-1:0] image_width,
  input  logic [DIM_W-1:0] image_height,
  input  logic [7:0]       in_r,
  input  logic [7:0]       in_g,
  input  logic [7:0]       in_b,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [31:0]      m_axis_tdata,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic             m_axis_tuser,
  output logic             m_axis_tlast,
  output logic             frame_done
);

  logic [47:0]      r_q;
  logic [2:0]       r_cnt;
  logic [DIM_W-1:0] r_x;
  logic [DIM_W-1:0] r_y;
  logic [DIM_W-1:0] r_w;
  logic [DIM_W-1:0] r_h;
  logic             r_flush;
  logic             r_fend_pend;
  logic             r_sof;
  logic [31:0]      r_tdata;
  logic             r_tvalid;
  logic             r_tuser;
  logic             r_tlast;
  logic             r_tfend;
  logic             r_frame_done;

  logic             w_origin;
  logic [DIM_W-1:0] w_w;
  logic [DIM_W-1:0] w_h;
  logic             w_dims_ok;
  logic             w_accept;
  logic             w_eol;
  logic             w_eof;
  logic             w_out_free;
  logic             w_move;
  logic             w_last;
  logic [47:0]      w_pix;

  // At the first pixel of a frame the live dimensions apply; afterwards the latched copy.
  assign w_origin  = (r_x == '0) && (r_y == '0);
  assign w_w       = w_origin ? image_width  : r_w;
  assign w_h       = w_origin ? image_height : r_h;
  assign w_dims_ok = (w_w != '0) && (w_h != '0);

  assign in_ready   = aresetn && (r_cnt <= 3'd3) && !r_flush && w_dims_ok;
  assign w_accept   = in_valid && in_ready;
  assign w_eol      = (r_x == w_w - DIM_W'(1));
  assign w_eof      = (r_y == w_h - DIM_W'(1));
  assign w_out_free = !r_tvalid || m_axis_tready;
  assign w_move     = w_out_free && ((r_cnt >= 3'd4) || (r_flush && (r_cnt != 3'd0)));
  assign w_last     = r_flush && (r_cnt <= 3'd4);
  assign w_pix      = {24'd0, in_b, in_g, in_r} << {r_cnt, 3'b000};

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_q          <= '0;
      r_cnt        <= '0;
      r_x          <= '0;
      r_y          <= '0;
      r_w          <= '0;
      r_h          <= '0;
      r_flush      <= 1'b0;
      r_fend_pend  <= 1'b0;
      r_sof        <= 1'b1;
      r_tdata      <= '0;
      r_tvalid     <= 1'b0;
      r_tuser      <= 1'b0;
      r_tlast      <= 1'b0;
      r_tfend      <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= r_tvalid && m_axis_tready && r_tlast && r_tfend;

      // Accept and move are mutually exclusive: accept needs <=3 bytes and no flush.
      if (w_accept) begin
        r_q   <= r_q | w_pix;
        r_cnt <= r_cnt + 3'd3;
        if (w_origin) begin
          r_w <= image_width;
          r_h <= image_height;
        end
        if (w_eol) begin
          r_x         <= '0;
          r_flush     <= 1'b1;
          r_fend_pend <= w_eof;
          r_y         <= w_eof ? '0 : r_y + DIM_W'(1);
        end else begin
          r_x <= r_x + DIM_W'(1);
        end
      end else if (w_move) begin
        r_q   <= {32'd0, r_q[47:32]};
        r_cnt <= (r_cnt >= 3'd4) ? r_cnt - 3'd4 : 3'd0;
        if (w_last) begin
          r_flush     <= 1'b0;
          r_fend_pend <= 1'b0;
        end
      end

      if (w_move) begin
        r_tdata  <= r_q[31:0];
        r_tvalid <= 1'b1;
        r_tuser  <= r_sof;
        r_tlast  <= w_last;
        r_tfend  <= w_last && r_fend_pend;
        r_sof    <= w_last && r_fend_pend;
      end else if (m_axis_tready) begin
        r_tvalid <= 1'b0;
      end
    end
  end

  assign m_axis_tdata  = r_tdata;
  assign m_axis_tvalid = r_tvalid;
  assign m_axis_tuser  = r_tuser;
  assign m_axis_tlast  = r_tlast;
  assign frame_done    = r_frame_done;

endmodule

// File: tb/tb_pixel_stream_packer.sv
// Bench for pixel_stream_packer: directed frames from the test plan plus randomized frames
// against a per-line byte-list reference model and an output scoreboard.
module tb_pixel_stream_packer;

  localparam int DIM_W = 13;

  logic             aclk = 1'b0;
  logic             aresetn = 1'b0;
  logic [DIM_W-1:0] image_width = '0;
  logic [DIM_W-1:0] image_height = '0;
  logic [7:0]       in_r = '0;
  logic [7:0]       in_g = '0;
  logic [7:0]       in_b = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [31:0]      m_axis_tdata;
  logic             m_axis_tvalid;
  logic             m_axis_tready = 1'b0;
  logic             m_axis_tuser;
  logic             m_axis_tlast;
  logic             frame_done;

  pixel_stream_packer #(.DIM_W(DIM_W)) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .image_width   (image_width),
    .image_height  (image_height),
    .in_r          (in_r),
    .in_g          (in_g),
    .in_b          (in_b),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tlast  (m_axis_tlast),
    .frame_done    (frame_done)
  );

  always #5 aclk = ~aclk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic        fe;
    logic        u;
    logic        l;
    logic [31:0] d;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] px_q[$];
  int         tr_mode = 0;  // 0: always ready, 1: random, 2: stalled
  int         cyc = 0;

  initial forever begin
    @(posedge aclk);
    #1;
    case (tr_mode)
      0:       m_axis_tready = 1'b1;
      1:       m_axis_tready = ($urandom_range(0, 3) != 0);
      default: m_axis_tready = 1'b0;
    endcase
  end

  always @(posedge aclk) cyc <= cyc + 1;

  // Output monitor: scoreboard, hold stability under backpressure, frame_done timing.
  logic        pend_fd = 1'b0;
  logic        hold_prev = 1'b0;
  logic [33:0] prev_out = '0;
  exp_t        mon_e;
  bit          lat_arm = 1'b0;
  int          lat_start = -1;
  int          lat_end = -1;

  always @(negedge aclk) begin
    if (!aresetn) begin
      pend_fd   = 1'b0;
      hold_prev = 1'b0;
    end else begin
      if (hold_prev)
        chk("hold", {m_axis_tvalid, m_axis_tuser, m_axis_tlast, m_axis_tdata}, {1'b1, prev_out});
      if (pend_fd || frame_done)
        chk("frame_done", frame_done, pend_fd);
      pend_fd = 1'b0;
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) begin
          chk("extra_word", m_axis_tvalid, 1'b0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("word", {m_axis_tuser, m_axis_tlast, m_axis_tdata}, {mon_e.u, mon_e.l, mon_e.d});
          pend_fd = mon_e.fe;
        end
      end
      hold_prev = m_axis_tvalid && !m_axis_tready;
      prev_out  = {m_axis_tuser, m_axis_tlast, m_axis_tdata};
      if (lat_arm && in_valid && in_ready && lat_start < 0) lat_start = cyc + 1;
      if (lat_arm && m_axis_tvalid && m_axis_tlast && lat_end < 0) lat_end = cyc;
    end
  end

  task automatic build_px(input int w, input int h, input bit seq);
    px_q.delete();
    for (int i = 0; i < 3 * w * h; i++)
      px_q.push_back(seq ? 8'(i + 1) : 8'($urandom));
  endtask

  // Reference: each line is its own byte list, cut into 4-byte words, tail zero-filled.
  task automatic model_frame(input int w, input int h);
    int   nb;
    int   nw;
    exp_t e;
    nb = 3 * w;
    nw = (nb + 3) / 4;
    for (int l = 0; l < h; l++) begin
      for (int k = 0; k < nw; k++) begin
        e = '0;
        for (int b = 0; b < 4; b++)
          if (4 * k + b < nb) e.d[8*b +: 8] = px_q[l * nb + 4 * k + b];
        e.u  = (l == 0) && (k == 0);
        e.l  = (k == nw - 1);
        e.fe = e.l && (l == h - 1);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic drive_frame(input int w, input int h, input bit gaps, input int scr_w, input int maxp);
    int guard;
    image_width  = DIM_W'(w);
    image_height = DIM_W'(h);
    for (int p = 0; p < maxp; p++) begin
      if (gaps) begin
        in_valid = 1'b0;
        repeat ($urandom_range(0, 2)) begin
          @(posedge aclk);
          #1;
        end
      end
      in_r     = px_q[3 * p];
      in_g     = px_q[3 * p + 1];
      in_b     = px_q[3 * p + 2];
      in_valid = 1'b1;
      guard    = 0;
      @(negedge aclk);
      while (!in_ready && guard < 300) begin
        guard++;
        @(negedge aclk);
      end
      if (!in_ready) begin
        chk("accept_timeout", in_ready, 1'b1);
        in_valid = 1'b0;
        return;
      end
      @(posedge aclk);
      #1;
      if (p == 0) begin
        if (scr_w >= 0) begin
          image_width = DIM_W'(scr_w);
        end else begin
          image_width  = DIM_W'($urandom_range(0, 12));
          image_height = DIM_W'($urandom_range(0, 4));
        end
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic run_frame(input int w, input int h, input bit seq, input bit gaps, input int scr_w);
    build_px(w, h, seq);
    model_frame(w, h);
    drive_frame(w, h, gaps, scr_w, w * h);
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 2000) begin
      @(negedge aclk);
      g++;
    end
    chk("drain", exp_q.size(), 0);
    repeat (3) @(negedge aclk);
    @(posedge aclk);
    #1;
  endtask

  initial begin
    int g;
    image_width  = 13'd4;
    image_height = 13'd1;
    #2;
    chk("reset_outputs", {in_ready, m_axis_tvalid, m_axis_tuser, m_axis_tlast, frame_done, m_axis_tdata}, 64'd0);
    repeat (3) @(posedge aclk);
    #1;
    aresetn = 1'b1;

    // W=4 H=1 back-to-back, tready high, plus end-to-end timing
    tr_mode = 0;
    lat_arm = 1'b1;
    run_frame(4, 1, 1'b1, 1'b0, -1);
    drain();
    lat_arm = 1'b0;
    chk("first_to_tlast_cycles", lat_end - lat_start, 6);

    // W=2 H=2, padded line tails
    run_frame(2, 2, 1'b1, 1'b0, -1);
    drain();

    // Backpressure: tready low while the first word sits in the output register
    tr_mode = 2;
    fork
      run_frame(4, 1, 1'b1, 1'b0, -1);
      begin
        g = 0;
        while (!m_axis_tvalid && g < 100) begin
          @(negedge aclk);
          g++;
        end
        chk("bp_tvalid", m_axis_tvalid, 1'b1);
        repeat (5) @(negedge aclk);
        chk("bp_in_ready", in_ready, 1'b0);
        chk("bp_tdata", m_axis_tdata, 32'h04030201);
        tr_mode = 0;
      end
    join
    drain();

    // Width changed mid-frame only takes effect on the next frame
    run_frame(4, 1, 1'b1, 1'b0, 8);
    run_frame(8, 1, 1'b1, 1'b0, -1);
    drain();

    // Zero width at frame start blocks input
    image_width  = 13'd0;
    image_height = 13'd1;
    in_r = 8'hAA; in_g = 8'hBB; in_b = 8'hCC;
    in_valid = 1'b1;
    repeat (6) @(negedge aclk);
    chk("zero_w_in_ready", in_ready, 1'b0);
    chk("zero_w_tvalid", m_axis_tvalid, 1'b0);
    in_valid = 1'b0;
    @(posedge aclk);
    #1;
    run_frame(4, 1, 1'b1, 1'b0, -1);
    drain();

    // Async reset after 2 pixels discards everything, next frame restarts with tuser
    tr_mode = 2;
    build_px(4, 1, 1'b1);
    drive_frame(4, 1, 1'b0, -1, 2);
    repeat (2) @(posedge aclk);
    #1;
    chk("pre_reset_tvalid", m_axis_tvalid, 1'b1);
    #2;
    aresetn = 1'b0;
    #1;
    chk("async_reset_outputs", {in_ready, m_axis_tvalid, m_axis_tuser, m_axis_tlast, frame_done, m_axis_tdata}, 64'd0);
    exp_q.delete();
    repeat (2) @(posedge aclk);
    #1;
    aresetn = 1'b1;
    tr_mode = 0;
    run_frame(4, 1, 1'b1, 1'b0, -1);
    drain();

    // Randomized frames with input gaps, random backpressure and scrambled live dims
    tr_mode = 1;
    for (int f = 0; f < 25; f++)
      run_frame($urandom_range(1, 9), $urandom_range(1, 3), 1'b0, 1'b1, -1);
    drain();
    tr_mode = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
